// File: rtl/event_recovery_array_pkg.sv
// Shared types for the multi-channel clock-event recovery block.
package event_recovery_array_pkg;

  localparam int DEF_PERIOD_W   = 16;
  localparam int DEF_LOCK_COUNT = 4;

  typedef struct packed {
    logic clk;
    logic rst;
  } clk_dom_s;

  typedef struct packed {
    logic pos;
    logic neg;
  } recovery_pins_s;

  typedef struct packed {
    logic rise;
    logic fall;
    logic either;
  } chan_events_s;

  typedef logic [DEF_PERIOD_W-1:0]             period_t;
  typedef logic [$clog2(DEF_LOCK_COUNT+1)-1:0] match_t;

endpackage

// File: rtl/event_recovery_array_channel.sv
// One recovery channel: two deglitch filters, skew check, period counter and lock tracker.
module event_recovery_array_channel
  import event_recovery_array_pkg::*;
#(
  parameter int FILTER_DEPTH = 3,
  parameter int SKEW_MAX     = 2,
  parameter int PERIOD_W     = 16,
  parameter int PERIOD_TOL   = 1,
  parameter int LOCK_COUNT   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                sel_i,
  input  logic                diff_en_i,
  input  logic                err_clear_i,
  input  logic                pos_i,
  input  logic                neg_i,
  output logic                primary_clk_o,
  output chan_events_s        events_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic                period_valid_o,
  output logic                locked_o,
  output logic                diff_err_o
);

  localparam int CW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
  localparam int SW = $clog2(SKEW_MAX + 2);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0]       CNT_LAST  = CW'(FILTER_DEPTH - 1);
  localparam logic [SW-1:0]       SKEW_LIM  = SW'(SKEW_MAX + 1);
  localparam logic [SW-1:0]       SKEW_TRIP = SW'(SKEW_MAX);
  localparam logic [MW-1:0]       MATCH_MAX = MW'(LOCK_COUNT);
  localparam logic [PERIOD_W-1:0] PCNT_MAX  = '1;
  localparam logic [PERIOD_W-1:0] TOL       = PERIOD_W'(PERIOD_TOL);

  // Returns {next filtered level, next stability count}.
  function automatic logic [CW:0] filt_step(input logic raw, input logic filt,
                                            input logic [CW-1:0] cnt);
    if (raw == filt)          return {filt, {CW{1'b0}}};
    else if (cnt == CNT_LAST) return {raw, {CW{1'b0}}};
    else                      return {filt, cnt + 1'b1};
  endfunction

  function automatic logic [PERIOD_W-1:0] abs_diff(input logic [PERIOD_W-1:0] a,
                                                   input logic [PERIOD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic                raw_pri, raw_sec, rise, fall, err_set;
  logic                filt_pri_q, filt_pri_d, filt_sec_q, filt_sec_d;
  logic [CW-1:0]       cnt_pri_q, cnt_pri_d, cnt_sec_q, cnt_sec_d;
  logic [SW-1:0]       skew_q, skew_d;
  logic                diff_err_q, diff_err_d;
  chan_events_s        events_q, events_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d, period_q, period_d, prev_q, prev_d;
  logic                seen_q, seen_d, pvalid_q, pvalid_d, prev_ok_q, prev_ok_d;
  logic [MW-1:0]       match_q, match_d;
  logic                locked_q, locked_d;

  assign raw_pri       = sel_i ? pos_i : neg_i;
  assign raw_sec       = sel_i ? neg_i : pos_i;
  assign primary_clk_o = raw_pri;

  always_comb begin
    {filt_pri_d, cnt_pri_d} = filt_step(raw_pri, filt_pri_q, cnt_pri_q);
    {filt_sec_d, cnt_sec_d} = filt_step(raw_sec, filt_sec_q, cnt_sec_q);
    rise            = ~filt_pri_q & filt_pri_d;
    fall            = filt_pri_q & ~filt_pri_d;
    events_d.rise   = rise;
    events_d.fall   = fall;
    events_d.either = rise | fall;

    skew_d  = '0;
    err_set = 1'b0;
    if (diff_en_i && (filt_pri_q == filt_sec_q)) begin
      skew_d  = (skew_q == SKEW_LIM) ? skew_q : skew_q + 1'b1;
      err_set = (skew_q >= SKEW_TRIP);
    end
    diff_err_d = err_set ? 1'b1 : (err_clear_i ? 1'b0 : diff_err_q);

    pcnt_d    = pcnt_q;
    seen_d    = seen_q;
    period_d  = period_q;
    pvalid_d  = 1'b0;
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    match_d   = match_q;
    locked_d  = locked_q;
    if (rise) begin
      // A rise coinciding with saturation still reports the saturated count.
      seen_d = 1'b1;
      pcnt_d = PERIOD_W'(1);
      if (seen_q) begin
        period_d  = pcnt_q;
        pvalid_d  = 1'b1;
        prev_d    = pcnt_q;
        prev_ok_d = 1'b1;
        if (prev_ok_q) begin
          if (abs_diff(pcnt_q, prev_q) <= TOL) begin
            match_d  = (match_q == MATCH_MAX) ? match_q : match_q + 1'b1;
            locked_d = (match_d == MATCH_MAX);
          end else begin
            match_d  = '0;
            locked_d = 1'b0;
          end
        end
      end
    end else if (seen_q) begin
      if (pcnt_q == PCNT_MAX) begin
        seen_d   = 1'b0;
        match_d  = '0;
        locked_d = 1'b0;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      filt_pri_q <= 1'b0;
      filt_sec_q <= 1'b0;
      cnt_pri_q  <= '0;
      cnt_sec_q  <= '0;
      skew_q     <= '0;
      diff_err_q <= 1'b0;
      events_q   <= '0;
      pcnt_q     <= '0;
      seen_q     <= 1'b0;
      period_q   <= '0;
      pvalid_q   <= 1'b0;
      prev_q     <= '0;
      prev_ok_q  <= 1'b0;
      match_q    <= '0;
      locked_q   <= 1'b0;
    end else begin
      filt_pri_q <= filt_pri_d;
      filt_sec_q <= filt_sec_d;
      cnt_pri_q  <= cnt_pri_d;
      cnt_sec_q  <= cnt_sec_d;
      skew_q     <= skew_d;
      diff_err_q <= diff_err_d;
      events_q   <= events_d;
      pcnt_q     <= pcnt_d;
      seen_q     <= seen_d;
      period_q   <= period_d;
      pvalid_q   <= pvalid_d;
      prev_q     <= prev_d;
      prev_ok_q  <= prev_ok_d;
      match_q    <= match_d;
      locked_q   <= locked_d;
    end
  end

  assign events_o       = events_q;
  assign period_o       = period_q;
  assign period_valid_o = pvalid_q;
  assign locked_o       = locked_q;
  assign diff_err_o     = diff_err_q;

endmodule

// File: rtl/event_recovery_array.sv
// Multi-channel clock-event recovery: independent channels fanned out from shared ports.
module event_recovery_array
  import event_recovery_array_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int FILTER_DEPTH = 3,
  parameter int SKEW_MAX     = 2,
  parameter int PERIOD_W     = 16,
  parameter int PERIOD_TOL   = 1,
  parameter int LOCK_COUNT   = 4
) (
  input  clk_dom_s                            sys_dom_i,
  input  logic           [CHANNELS-1:0]       chan_en_i,
  input  logic           [CHANNELS-1:0]       source_select_i,
  input  logic           [CHANNELS-1:0]       diff_en_i,
  input  logic           [CHANNELS-1:0]       err_clear_i,
  input  recovery_pins_s [CHANNELS-1:0]       io_clk_i,
  output logic           [CHANNELS-1:0]       primary_clk_o,
  output chan_events_s   [CHANNELS-1:0]       events_o,
  output logic [CHANNELS-1:0][PERIOD_W-1:0]   period_o,
  output logic           [CHANNELS-1:0]       period_valid_o,
  output logic           [CHANNELS-1:0]       locked_o,
  output logic           [CHANNELS-1:0]       diff_err_o
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    event_recovery_array_channel #(
      .FILTER_DEPTH (FILTER_DEPTH),
      .SKEW_MAX     (SKEW_MAX),
      .PERIOD_W     (PERIOD_W),
      .PERIOD_TOL   (PERIOD_TOL),
      .LOCK_COUNT   (LOCK_COUNT)
    ) u_chan (
      .clk_i          (sys_dom_i.clk),
      .rst_i          (sys_dom_i.rst),
      .en_i           (chan_en_i[g]),
      .sel_i          (source_select_i[g]),
      .diff_en_i      (diff_en_i[g]),
      .err_clear_i    (err_clear_i[g]),
      .pos_i          (io_clk_i[g].pos),
      .neg_i          (io_clk_i[g].neg),
      .primary_clk_o  (primary_clk_o[g]),
      .events_o       (events_o[g]),
      .period_o       (period_o[g]),
      .period_valid_o (period_valid_o[g]),
      .locked_o       (locked_o[g]),
      .diff_err_o     (diff_err_o[g])
    );
  end

endmodule

// File: tb/tb_event_recovery_array.sv
// Directed bench with an event/period scoreboard for channel 0 and spot checks elsewhere.
module tb_event_recovery_array;
  import event_recovery_array_pkg::*;

  localparam int NCH = 4;
  localparam int PW  = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  clk_dom_s              dom;
  logic [NCH-1:0]        chan_en, sel, diff_en, err_clear;
  recovery_pins_s [NCH-1:0] io;
  logic [NCH-1:0]        primary_clk;
  chan_events_s [NCH-1:0] events;
  logic [NCH-1:0][PW-1:0] period;
  logic [NCH-1:0]        period_valid, locked, diff_err;

  assign dom.clk = clk;
  assign dom.rst = rst;

  event_recovery_array #(
    .CHANNELS(NCH), .FILTER_DEPTH(3), .SKEW_MAX(2),
    .PERIOD_W(PW), .PERIOD_TOL(1), .LOCK_COUNT(4)
  ) dut (
    .sys_dom_i       (dom),
    .chan_en_i       (chan_en),
    .source_select_i (sel),
    .diff_en_i       (diff_en),
    .err_clear_i     (err_clear),
    .io_clk_i        (io),
    .primary_clk_o   (primary_clk),
    .events_o        (events),
    .period_o        (period),
    .period_valid_o  (period_valid),
    .locked_o        (locked),
    .diff_err_o      (diff_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nerr = 0;
  int nchecks = 0;

  typedef struct { int cyc; logic rise; } ev_t;
  typedef struct { int cyc; int per; logic lck; } per_t;
  ev_t  evq[$];
  per_t perq[$];

  // Channel-0 reference state
  logic m_filt, m_seen, m_pvalid, m_locked;
  int   m_last, m_prev, m_match;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tickn(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_filt = 1'b0; m_seen = 1'b0; m_pvalid = 1'b0; m_locked = 1'b0;
    m_last = 0; m_prev = 0; m_match = 0;
  endtask

  task automatic model_rise(input int e);
    int p, d;
    if (m_seen && (e - m_last) <= 255) begin
      p = e - m_last;
      if (m_pvalid) begin
        d = (p > m_prev) ? p - m_prev : m_prev - p;
        if (d <= 1) begin
          if (m_match < 4) m_match++;
          m_locked = (m_match == 4);
        end else begin
          m_match = 0;
          m_locked = 1'b0;
        end
      end
      m_prev = p;
      m_pvalid = 1'b1;
      perq.push_back('{e, p, m_locked});
    end else if (m_seen) begin
      m_match = 0;
      m_locked = 1'b0;
    end
    m_seen = 1'b1;
    m_last = e;
  endtask

  // Drive channel-0 (mirrored on channel 1) pos pin to v for n cycles.
  task automatic drive_run(input logic v, input int n);
    int e;
    io[0].pos = v;
    io[1].pos = v;
    if (v != m_filt && n >= 3) begin
      e = cyc + 3;
      evq.push_back('{e, v});
      m_filt = v;
      if (v) model_rise(e);
    end
    tickn(n);
  endtask

  task automatic square(input int nper, input int len);
    for (int i = 0; i < nper; i++) begin
      drive_run(1'b1, 5);
      drive_run(1'b0, len - 5);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_events"}, 32'(events), 32'h0);
    check({tag, "_period"}, period, 32'h0);
    check({tag, "_pvalid"}, 32'(period_valid), 32'h0);
    check({tag, "_locked"}, 32'(locked), 32'h0);
    check({tag, "_differr"}, 32'(diff_err), 32'h0);
  endtask

  task automatic do_reset(input string tag);
    check({tag, "_evq_drained"}, evq.size(), 0);
    check({tag, "_perq_drained"}, perq.size(), 0);
    rst = 1'b1;
    io[0].pos = 1'b0;
    io[1].pos = 1'b0;
    tickn(1);
    evq.delete();
    perq.delete();
    model_reset();
    check_all_zero(tag);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    ev_t  e;
    per_t p;
    while (evq.size() > 0 && evq[0].cyc < cyc) begin
      check("ev_missed_cycle", cyc, evq[0].cyc);
      void'(evq.pop_front());
    end
    while (perq.size() > 0 && perq[0].cyc < cyc) begin
      check("per_missed_cycle", cyc, perq[0].cyc);
      void'(perq.pop_front());
    end
    if (events[0] !== 3'b000) begin
      if (evq.size() == 0) check("ev_unexpected", 32'(events[0]), 32'h0);
      else begin
        e = evq.pop_front();
        check("ev_cycle", cyc, e.cyc);
        check("ev_kind", 32'(events[0]), {29'd0, e.rise, ~e.rise, 1'b1});
      end
    end
    if (period_valid[0] !== 1'b0) begin
      if (perq.size() == 0) check("pv_unexpected", 32'(period_valid[0]), 32'h0);
      else begin
        p = perq.pop_front();
        check("pv_cycle", cyc, p.cyc);
        check("pv_period", 32'(period[0]), p.per);
        check("pv_locked", 32'(locked[0]), 32'(p.lck));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    chan_en = '1; sel = '1; diff_en = '0; err_clear = '0; io = '0;
    model_reset();
    tickn(2);
    do_reset("reset_init");

    // Source selection is a raw combinational mux.
    io[2].pos = 1'b1; #1;
    check("psel_pos", 32'(primary_clk[2]), 32'h1);
    sel[2] = 1'b0; #1;
    check("psel_swap_low", 32'(primary_clk[2]), 32'h0);
    io[2].neg = 1'b1; #1;
    check("psel_swap_high", 32'(primary_clk[2]), 32'h1);
    io[2] = '0; sel[2] = 1'b1;
    tickn(1);

    // Glitch rejection and filtered edges
    drive_run(1'b1, 2);
    drive_run(1'b0, 5);
    drive_run(1'b1, 3);
    drive_run(1'b0, 6);
    do_reset("reset_t2");

    // Lock acquisition on a period-10 square wave
    square(5, 10);
    check("lock_not_yet", 32'(locked[0]), 32'h0);
    square(1, 10);
    check("lock_rise6", 32'(locked[0]), 32'h1);
    check("period10", 32'(period[0]), 32'd10);

    // Tolerance: 11 holds, 13 after 11 drops, four 13s relock
    square(1, 11);
    square(1, 13);
    square(1, 13);
    check("unlock_diff2", 32'(locked[0]), 32'h0);
    square(4, 13);
    check("relock", 32'(locked[0]), 32'h1);

    // Stall: hold primary high until the period counter saturates
    drive_run(1'b1, 3);
    tickn(254);
    check("stall_pre_sat_locked", 32'(locked[0]), 32'h1);
    tickn(1);
    check("stall_unlock", 32'(locked[0]), 32'h0);
    check("stall_period_held", 32'(period[0]), 32'd13);
    tickn(10);
    drive_run(1'b0, 5);
    drive_run(1'b1, 5);
    drive_run(1'b0, 5);
    drive_run(1'b1, 5);
    check("post_stall_period", 32'(period[0]), 32'd10);
    drive_run(1'b0, 5);

    // Differential check on channel 3
    io[3].pos = 1'b1;
    tickn(5);
    diff_en[3] = 1'b1;
    tickn(6);
    check("diff_ok", 32'(diff_err[3]), 32'h0);
    io[3].neg = 1'b1;
    tickn(5);
    check("diff_pre_err", 32'(diff_err[3]), 32'h0);
    tickn(1);
    check("diff_err_set", 32'(diff_err[3]), 32'h1);
    io[3].neg = 1'b0;
    tickn(4);
    check("diff_err_sticky", 32'(diff_err[3]), 32'h1);
    err_clear[3] = 1'b1;
    tickn(1);
    err_clear[3] = 1'b0;
    check("diff_err_cleared", 32'(diff_err[3]), 32'h0);
    io[3].neg = 1'b1;
    tickn(6);
    check("diff_err_again", 32'(diff_err[3]), 32'h1);
    err_clear[3] = 1'b1;
    tickn(1);
    err_clear[3] = 1'b0;
    check("diff_set_beats_clear", 32'(diff_err[3]), 32'h1);
    diff_en[3] = 1'b0;
    tickn(3);
    check("diff_disabled_keeps", 32'(diff_err[3]), 32'h1);
    err_clear[3] = 1'b1;
    tickn(1);
    err_clear[3] = 1'b0;
    check("diff_disabled_clear", 32'(diff_err[3]), 32'h0);
    tickn(5);
    check("diff_disabled_no_set", 32'(diff_err[3]), 32'h0);
    io[3] = '0;

    // Isolation: channel 1 disabled while channel 0 locks on the same wave
    do_reset("reset_t6");
    chan_en[1] = 1'b0;
    square(6, 10);
    check("iso_ch0_locked", 32'(locked[0]), 32'h1);
    check("iso_ch0_period", 32'(period[0]), 32'd10);
    check("iso_ch1_locked", 32'(locked[1]), 32'h0);
    check("iso_ch1_period", 32'(period[1]), 32'h0);
    check("iso_ch1_pvalid", 32'(period_valid[1]), 32'h0);

    // Reset in the middle of a locked high phase
    drive_run(1'b1, 4);
    check("midlock_locked", 32'(locked[0]), 32'h1);
    do_reset("reset_midlock");
    chan_en[1] = 1'b1;
    tickn(5);
    check("final_evq_empty", evq.size(), 0);
    check("final_perq_empty", perq.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
